adc_modulation: RTL

ADC_MODULATION -- requirements
Module: adc_modulation

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_sync2.sv | 21 ++
 rtl/adc_modulation.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types for the charge-balancing ADC sequencer: FSM states and reference-mux codes.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_SIGNAL,
        ST_RUNDOWN,
        ST_DONE
    } adc_state_t;

    localparam logic [1:0] REFMUX_OFF = 2'b00;
    localparam logic [1:0] REFMUX_POS = 2'b01;
    localparam logic [1:0] REFMUX_NEG = 2'b10;

endpackage

// File: rtl/adc_sync2.sv
// Two-flop synchroniser for the asynchronous integrator comparator.
module adc_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_modulation.sv
// Multi-slope ADC sequencer: integrator reset, modulated signal phase, rundown timing.
// Define ADC_MODULATION_MONITOR_EN to register debug taps onto the monitor port.
module adc_modulation
    import adc_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int MOD_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] clk_count_reset_n,
    input  logic [CNT_W-1:0] clk_count_sig_n,
    input  logic [MOD_W-1:0] mod_period,
    input  logic             comparator_val,
    input  logic             adc_measure_trig,
    output logic             cmpr_latch,
    output logic             sigmux,
    output logic             resetmux,
    output logic [1:0]       refmux,
    output logic             adc_measure_valid,
    output logic [CNT_W-1:0] count_up,
    output logic [CNT_W-1:0] count_down,
    output logic [CNT_W-1:0] count_rundown,
    output logic             adc_overflow,
    output logic [5:0]       monitor
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [MOD_W-1:0] MOD_ONE = MOD_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic             cmp_s;
    adc_state_t       state;
    logic [CNT_W-1:0] phase_cnt;
    logic [MOD_W-1:0] mod_cnt;
    logic             rec_cmp;
    logic [CNT_W-1:0] reset_len, sig_len;
    logic             mod_last;

    adc_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (comparator_val),
        .q     (cmp_s)
    );

    // phase_cnt holds remaining cycles/periods minus one, so zero lengths collapse to one
    assign reset_len = (clk_count_reset_n == '0) ? '0 : clk_count_reset_n - CNT_ONE;
    assign sig_len   = (clk_count_sig_n == '0) ? '0 : clk_count_sig_n - CNT_ONE;
    assign mod_last  = (mod_period == '0) || (mod_cnt == mod_period - MOD_ONE);

    // The period decision is taken on the edge that starts the period so refmux
    // is already valid for every cycle of it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= ST_IDLE;
            refmux            <= REFMUX_OFF;
            sigmux            <= 1'b0;
            resetmux          <= 1'b1;
            cmpr_latch        <= 1'b1;
            adc_measure_valid <= 1'b0;
            adc_overflow      <= 1'b0;
            count_up          <= '0;
            count_down        <= '0;
            count_rundown     <= '0;
            phase_cnt         <= '0;
            mod_cnt           <= '0;
            rec_cmp           <= 1'b0;
        end else if (adc_measure_trig) begin
            state             <= ST_RESET;
            refmux            <= REFMUX_OFF;
            sigmux            <= 1'b0;
            resetmux          <= 1'b1;
            cmpr_latch        <= 1'b0;
            adc_measure_valid <= 1'b0;
            adc_overflow      <= 1'b0;
            count_up          <= '0;
            count_down        <= '0;
            count_rundown     <= '0;
            phase_cnt         <= reset_len;
            mod_cnt           <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (phase_cnt == '0) begin
                        state     <= ST_SIGNAL;
                        resetmux  <= 1'b0;
                        sigmux    <= 1'b1;
                        phase_cnt <= sig_len;
                        mod_cnt   <= '0;
                        if (cmp_s) begin
                            refmux     <= REFMUX_NEG;
                            count_down <= sat_inc(count_down);
                        end else begin
                            refmux   <= REFMUX_POS;
                            count_up <= sat_inc(count_up);
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                ST_SIGNAL: begin
                    if (mod_last) begin
                        mod_cnt <= '0;
                        if (phase_cnt == '0) begin
                            state   <= ST_RUNDOWN;
                            sigmux  <= 1'b0;
                            rec_cmp <= cmp_s;
                            refmux  <= cmp_s ? REFMUX_NEG : REFMUX_POS;
                        end else begin
                            phase_cnt <= phase_cnt - CNT_ONE;
                            if (cmp_s) begin
                                refmux     <= REFMUX_NEG;
                                count_down <= sat_inc(count_down);
                            end else begin
                                refmux   <= REFMUX_POS;
                                count_up <= sat_inc(count_up);
                            end
                        end
                    end else begin
                        mod_cnt <= mod_cnt + MOD_ONE;
                    end
                end
                ST_RUNDOWN: begin
                    if ((cmp_s != rec_cmp) || (&count_rundown)) begin
                        state             <= ST_DONE;
                        adc_overflow      <= (cmp_s == rec_cmp);
                        refmux            <= REFMUX_OFF;
                        resetmux          <= 1'b1;
                        cmpr_latch        <= 1'b1;
                        adc_measure_valid <= 1'b1;
                    end else begin
                        count_rundown <= count_rundown + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADC_MODULATION_MONITOR_EN
    logic [5:0] monitor_q;

    always_ff @(posedge clk) begin
        if (!reset) monitor_q <= '0;
        else        monitor_q <= {adc_overflow, adc_measure_valid, adc_measure_trig, cmp_s, refmux};
    end

    assign monitor = monitor_q;
`else
    assign monitor = 6'b0;
`endif

endmodule
